vga_timing_gen_param: RTL and testbench
=======================================

Name: vga_timing_gen_param

Overview:
- Parametrised raster timing generator for the pixel output path.
- Produces hsync, vsync and data-enable from configurable horizontal and vertical timing.
- Pulls pixels from a show-ahead (first-word-fall-through) pixel FIFO and drives a half-width DDR pixel bus to the DAC/encoder.
- Adds to the previous generation: configurable geometry, sync polarity, underflow policy (stall or free-run with fill colour), sticky underflow status, frame-start strobe, pixel coordinates and registered, aligned outputs.

Parameters:
- PIX_W, 24, pixel width in bits; must be even. The DDR bus is PIX_W/2.
- H_SYNC, 96, hsync pulse width in clocks.
- H_BP, 48, horizontal back porch.
- H_ACT, 640, active pixels per line.
- H_FP, 16, horizontal front porch.
- V_SYNC, 2, vsync pulse width in lines.
- V_BP, 33, vertical back porch.
- V_ACT, 480, active lines.
- V_FP, 10, vertical front porch.
- SYNC_POL, 0, asserted level of hsync/vsync: 0 = active-low, 1 = active-high.
- STALL_ON_EMPTY, 1, underflow policy: 1 = freeze raster while FIFO empty; 0 = free-run and output FILL_COLOR.
- FILL_COLOR, 24'h000000, pixel driven on underflow and outside active video.
- CNT_W, 11, width of the h/v counters; must hold H_TOTAL-1 and V_TOTAL-1.

Ports:
- clk  in  1  pixel clock.
- rst_n  in  1  synchronous, active-low reset.
- en  in  1  raster advance enable; counters hold when low.
- fifo_data  in  PIX_W  show-ahead FIFO head word.
- fifo_empty  in  1  FIFO empty flag.
- rd_en  out  1  FIFO pop; combinational.
- hsync  out  1  registered horizontal sync.
- vsync  out  1  registered vertical sync.
- de  out  1  registered data enable (active video).
- D  out  PIX_W/2  DDR pixel bus: pix_q[PIX_W/2-1:0] while clk high, pix_q[PIX_W-1:PIX_W/2] while clk low.
- pix_x  out  CNT_W  registered active-area column; 0 outside active video.
- pix_y  out  CNT_W  registered active-area row; 0 outside active video.
- frame_start  out  1  registered one-clock pulse at raster (0,0).
- underflow  out  1  sticky underflow flag.
- clr_underflow  in  1  clears underflow.

Behaviour:
- H_TOTAL = H_SYNC+H_BP+H_ACT+H_FP. V_TOTAL = V_SYNC+V_BP+V_ACT+V_FP.
- Region order on each axis: sync, back porch, active, front porch. Count 0 is the first sync clock.
- Active region: hcnt in [H_SYNC+H_BP, H_SYNC+H_BP+H_ACT-1] and vcnt in [V_SYNC+V_BP, V_SYNC+V_BP+V_ACT-1]. Call this act.
- adv (counters step this cycle):
  - en && !(STALL_ON_EMPTY && act && fifo_empty).
  - With STALL_ON_EMPTY=1, blanking intervals still advance while the FIFO is empty.
- On adv:
  - hcnt wraps H_TOTAL-1 -> 0; otherwise increments.
  - vcnt increments only on the hcnt wrap, and wraps V_TOTAL-1 -> 0.
- rd_en = adv && act && !fifo_empty. Never pops an empty FIFO.
- Output register, updated only when adv:
  - hsync = (hcnt<H_SYNC) XNOR SYNC_POL.
  - vsync = (vcnt<V_SYNC) XNOR SYNC_POL.
  - de = act.
  - pix_q = fifo_data if rd_en, else FILL_COLOR.
  - pix_x/pix_y = hcnt/vcnt minus their active offsets when act, else 0.
  - frame_start = (hcnt==0 && vcnt==0).
- Latency: outputs reflect the counter values one clock earlier. All outputs hold their values while adv is low.
- frame_start is forced to 0 on any cycle where adv is low.
- Underflow:
  - Set when en && act && fifo_empty, in both modes.
  - Held until clr_underflow. If set and clear occur in the same cycle, set wins.
- Reset (rst_n low at a clk edge):
  - Counters 0, pix_q=FILL_COLOR, de=0, pix_x=pix_y=0, frame_start=0, underflow=0.
  - hsync/vsync at their deasserted level (= !SYNC_POL).
  - Reset mid-frame aborts the frame; the next adv starts at (0,0).
- D is a combinational mux on clk level, matching the existing DDR pixel interface.

Test Plan:
- Defaults, en=1, FIFO never empty, run 2 frames:
  - hsync low for 96 of every 800 clocks.
  - vsync low for 2 of every 525 lines.
  - de high for 640×480 clocks per frame.
  - frame_start pulses exactly once per 420000 clocks.
- FIFO feeds an incrementing pattern:
  - First de cycle gives pix_x=0, pix_y=0, pix_q=first word.
  - D = low half while clk high, upper half while clk low.
  - Last active pixel gives pix_x=639, pix_y=479.
- STALL_ON_EMPTY=1, fifo_empty for 10 clocks at hcnt=200:
  - Counters and outputs freeze; rd_en=0; underflow=1.
  - Resumes at hcnt=200 with no pixel lost.
- STALL_ON_EMPTY=0, same stimulus:
  - Raster continues; de=1 with D=FILL_COLOR halves for 10 pixels; underflow=1.
  - clr_underflow pulse clears it; a coincident new underflow keeps it at 1.
- SYNC_POL=1, small geometry (H 2/2/4/2, V 1/1/3/1):
  - Syncs active-high; exact region boundaries checked on every clock.
- rst_n low at hcnt=500, vcnt=300 for 1 clock:
  - Next clock outputs at reset values; the first adv after release produces frame_start=1.

Source files
------------

// File: rtl/vga_timing_gen_param.sv
// vga_timing_gen_param
// ---------------------------------------------------------------------------
// Parametrised raster timing generator. It walks a horizontal/vertical
// counter pair through sync, back porch, active and front porch. During
// active video it pops pixels from a show-ahead FIFO. It presents a
// registered, aligned set of sync/enable/coordinate outputs and a half-width
// DDR pixel bus.
//
// Ports
//   clk            pixel clock
//   rst_n          synchronous active-low reset
//   en             raster advance enable (counters hold while low)
//   fifo_data      show-ahead FIFO head word (PIX_W)
//   fifo_empty     FIFO empty flag
//   rd_en          FIFO pop, combinational
//   hsync, vsync   registered syncs, asserted level = SYNC_POL
//   de             registered data enable
//   D              DDR pixel bus (PIX_W/2): low half while clk high,
//                  upper half while clk low
//   pix_x, pix_y   registered active-area coordinates, 0 in blanking
//   frame_start    registered one-clock pulse at raster (0,0)
//   underflow      sticky underflow flag
//   clr_underflow  clears underflow (a coincident new underflow wins)
// ---------------------------------------------------------------------------
module vga_timing_gen_param #(
   parameter int                PIX_W          = 24,
   parameter int                H_SYNC         = 96,
   parameter int                H_BP           = 48,
   parameter int                H_ACT          = 640,
   parameter int                H_FP           = 16,
   parameter int                V_SYNC         = 2,
   parameter int                V_BP           = 33,
   parameter int                V_ACT          = 480,
   parameter int                V_FP           = 10,
   parameter int                SYNC_POL       = 0,
   parameter int                STALL_ON_EMPTY = 1,
   parameter logic [PIX_W-1:0]  FILL_COLOR     = '0,
   parameter int                CNT_W          = 11
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 en,
   input  logic [PIX_W-1:0]     fifo_data,
   input  logic                 fifo_empty,
   output logic                 rd_en,
   output logic                 hsync,
   output logic                 vsync,
   output logic                 de,
   output logic [PIX_W/2-1:0]   D,
   output logic [CNT_W-1:0]     pix_x,
   output logic [CNT_W-1:0]     pix_y,
   output logic                 frame_start,
   output logic                 underflow,
   input  logic                 clr_underflow
);

   localparam int HALF        = PIX_W / 2;
   localparam int H_TOTAL     = H_SYNC + H_BP + H_ACT + H_FP;
   localparam int V_TOTAL     = V_SYNC + V_BP + V_ACT + V_FP;
   localparam int H_ACT_START = H_SYNC + H_BP;
   localparam int V_ACT_START = V_SYNC + V_BP;

   localparam logic [CNT_W-1:0] H_LAST_C  = CNT_W'(H_TOTAL - 1);
   localparam logic [CNT_W-1:0] V_LAST_C  = CNT_W'(V_TOTAL - 1);
   localparam logic [CNT_W-1:0] H_SYNC_C  = CNT_W'(H_SYNC);
   localparam logic [CNT_W-1:0] V_SYNC_C  = CNT_W'(V_SYNC);
   localparam logic [CNT_W-1:0] H_ACT_S_C = CNT_W'(H_ACT_START);
   localparam logic [CNT_W-1:0] H_ACT_E_C = CNT_W'(H_ACT_START + H_ACT - 1);
   localparam logic [CNT_W-1:0] V_ACT_S_C = CNT_W'(V_ACT_START);
   localparam logic [CNT_W-1:0] V_ACT_E_C = CNT_W'(V_ACT_START + V_ACT - 1);

   localparam logic SYNC_ON  = (SYNC_POL != 0);
   localparam logic STALL_ON = (STALL_ON_EMPTY != 0);

   logic [CNT_W-1:0] hcnt_p0;
   logic [CNT_W-1:0] vcnt_p0;
   logic             act_p0;
   logic             adv_p0;
   logic [PIX_W-1:0] pix_q;

   // ---- stage p0: raster position, region decode, advance/pop decisions ----
   always_comb begin
      act_p0 = (hcnt_p0 >= H_ACT_S_C) && (hcnt_p0 <= H_ACT_E_C) &&
               (vcnt_p0 >= V_ACT_S_C) && (vcnt_p0 <= V_ACT_E_C);
      // In stall mode only an empty FIFO during active video freezes the
      // raster; blanking keeps running so sync timing is preserved.
      adv_p0 = en && !(STALL_ON && act_p0 && fifo_empty);
   end

   assign rd_en = adv_p0 && act_p0 && !fifo_empty;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         hcnt_p0 <= '0;
         vcnt_p0 <= '0;
      end else if (adv_p0) begin
         if (hcnt_p0 == H_LAST_C) begin
            hcnt_p0 <= '0;
            vcnt_p0 <= (vcnt_p0 == V_LAST_C) ? '0 : vcnt_p0 + 1'b1;
         end else begin
            hcnt_p0 <= hcnt_p0 + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         underflow <= 1'b0;
      end else if (en && act_p0 && fifo_empty) begin
         underflow <= 1'b1;
      end else if (clr_underflow) begin
         underflow <= 1'b0;
      end
   end

   // ---- stage p1: aligned output register ----
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         hsync       <= !SYNC_ON;
         vsync       <= !SYNC_ON;
         de          <= 1'b0;
         pix_q       <= FILL_COLOR;
         pix_x       <= '0;
         pix_y       <= '0;
         frame_start <= 1'b0;
      end else if (adv_p0) begin
         hsync       <= (hcnt_p0 < H_SYNC_C) ~^ SYNC_ON;
         vsync       <= (vcnt_p0 < V_SYNC_C) ~^ SYNC_ON;
         de          <= act_p0;
         pix_q       <= rd_en ? fifo_data : FILL_COLOR;
         pix_x       <= act_p0 ? hcnt_p0 - H_ACT_S_C : '0;
         pix_y       <= act_p0 ? vcnt_p0 - V_ACT_S_C : '0;
         frame_start <= (hcnt_p0 == '0) && (vcnt_p0 == '0);
      end else begin
         // The strobe must not stretch across a stall.
         frame_start <= 1'b0;
      end
   end

   // DDR pixel bus: the downstream encoder latches the low half on the
   // high phase and the upper half on the low phase.
   assign D = clk ? pix_q[HALF-1:0] : pix_q[PIX_W-1:HALF];

endmodule

// File: tb/tb_vga_timing_gen_param.sv
module tb_vga_timing_gen_param;

   typedef struct {
      int          hs, hbp, hact, hfp;
      int          vs, vbp, vact, vfp;
      bit          pol, stall;
      logic [23:0] fill;
   } geom_t;

   typedef struct {
      int          pos;
      bit          hs, vs, de, fs, uf;
      int          px, py;
      logic [23:0] pq;
   } mstate_t;

   localparam int NI    = 3;
   localparam int NITER = 12000;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic        en         [NI];
   logic        fifo_empty [NI];
   logic        clr        [NI];
   logic [23:0] fdata      [NI];
   logic        rd_en      [NI];
   logic        hsync      [NI];
   logic        vsync      [NI];
   logic        de         [NI];
   logic        fs         [NI];
   logic        uf         [NI];
   logic [11:0] d          [NI];
   logic [10:0] px         [NI];
   logic [10:0] py         [NI];

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // u0: small geometry, active-low syncs, stall on empty
   vga_timing_gen_param #(.PIX_W(24), .H_SYNC(8), .H_BP(6), .H_ACT(20), .H_FP(4),
      .V_SYNC(2), .V_BP(3), .V_ACT(12), .V_FP(2), .SYNC_POL(0), .STALL_ON_EMPTY(1),
      .FILL_COLOR(24'hA5C3E1), .CNT_W(11)) u0 (
      .clk(clk), .rst_n(rst_n), .en(en[0]), .fifo_data(fdata[0]), .fifo_empty(fifo_empty[0]),
      .rd_en(rd_en[0]), .hsync(hsync[0]), .vsync(vsync[0]), .de(de[0]), .D(d[0]),
      .pix_x(px[0]), .pix_y(py[0]), .frame_start(fs[0]), .underflow(uf[0]),
      .clr_underflow(clr[0]));

   // u1: same geometry, free-run with fill colour
   vga_timing_gen_param #(.PIX_W(24), .H_SYNC(8), .H_BP(6), .H_ACT(20), .H_FP(4),
      .V_SYNC(2), .V_BP(3), .V_ACT(12), .V_FP(2), .SYNC_POL(0), .STALL_ON_EMPTY(0),
      .FILL_COLOR(24'h5A3C1E), .CNT_W(11)) u1 (
      .clk(clk), .rst_n(rst_n), .en(en[1]), .fifo_data(fdata[1]), .fifo_empty(fifo_empty[1]),
      .rd_en(rd_en[1]), .hsync(hsync[1]), .vsync(vsync[1]), .de(de[1]), .D(d[1]),
      .pix_x(px[1]), .pix_y(py[1]), .frame_start(fs[1]), .underflow(uf[1]),
      .clr_underflow(clr[1]));

   // u2: tiny geometry H 2/2/4/2, V 1/1/3/1, active-high syncs
   vga_timing_gen_param #(.PIX_W(24), .H_SYNC(2), .H_BP(2), .H_ACT(4), .H_FP(2),
      .V_SYNC(1), .V_BP(1), .V_ACT(3), .V_FP(1), .SYNC_POL(1), .STALL_ON_EMPTY(1),
      .FILL_COLOR(24'h123456), .CNT_W(11)) u2 (
      .clk(clk), .rst_n(rst_n), .en(en[2]), .fifo_data(fdata[2]), .fifo_empty(fifo_empty[2]),
      .rd_en(rd_en[2]), .hsync(hsync[2]), .vsync(vsync[2]), .de(de[2]), .D(d[2]),
      .pix_x(px[2]), .pix_y(py[2]), .frame_start(fs[2]), .underflow(uf[2]),
      .clr_underflow(clr[2]));

   // ---------------- reference model (linear raster position) ----------------
   function automatic int ht(geom_t g);
      return g.hs + g.hbp + g.hact + g.hfp;
   endfunction

   function automatic int ft(geom_t g);
      return ht(g) * (g.vs + g.vbp + g.vact + g.vfp);
   endfunction

   function automatic bit in_act(geom_t g, int pos);
      int h;
      int v;
      h = pos % ht(g);
      v = pos / ht(g);
      return (h >= g.hs + g.hbp) && (h < g.hs + g.hbp + g.hact) &&
             (v >= g.vs + g.vbp) && (v < g.vs + g.vbp + g.vact);
   endfunction

   function automatic bit m_adv(geom_t g, mstate_t s, bit en_i, bit emp);
      return en_i && !(g.stall && in_act(g, s.pos) && emp);
   endfunction

   function automatic bit m_rd(geom_t g, mstate_t s, bit en_i, bit emp);
      return m_adv(g, s, en_i, emp) && in_act(g, s.pos) && !emp;
   endfunction

   function automatic mstate_t m_reset(geom_t g);
      mstate_t n;
      n.pos = 0;
      n.hs  = !g.pol;
      n.vs  = !g.pol;
      n.de  = 1'b0;
      n.fs  = 1'b0;
      n.uf  = 1'b0;
      n.px  = 0;
      n.py  = 0;
      n.pq  = g.fill;
      return n;
   endfunction

   function automatic mstate_t m_step(geom_t g, mstate_t s, bit rst_i, bit en_i, bit emp,
                                      bit clr_i, logic [23:0] data);
      mstate_t n;
      int h;
      int v;
      bit a;
      if (!rst_i) return m_reset(g);
      n = s;
      h = s.pos % ht(g);
      v = s.pos / ht(g);
      a = in_act(g, s.pos);
      if (en_i && a && emp) n.uf = 1'b1;
      else if (clr_i)       n.uf = 1'b0;
      if (m_adv(g, s, en_i, emp)) begin
         n.hs  = (h < g.hs) ? g.pol : !g.pol;
         n.vs  = (v < g.vs) ? g.pol : !g.pol;
         n.de  = a;
         n.pq  = m_rd(g, s, en_i, emp) ? data : g.fill;
         n.px  = a ? h - (g.hs + g.hbp) : 0;
         n.py  = a ? v - (g.vs + g.vbp) : 0;
         n.fs  = (s.pos == 0);
         n.pos = (s.pos + 1) % ft(g);
      end else begin
         n.fs = 1'b0;
      end
      return n;
   endfunction

   // ---------------------------------------------------------------------------
   geom_t   g        [NI];
   mstate_t m        [NI];
   int      seq      [NI];
   int      emp_left [NI];
   int      cnt_de   [NI];
   int      cnt_fs   [NI];
   int      cnt_hs   [NI];
   int      cnt_vs   [NI];

   initial begin
      g[0] = '{hs:8, hbp:6, hact:20, hfp:4, vs:2, vbp:3, vact:12, vfp:2,
               pol:1'b0, stall:1'b1, fill:24'hA5C3E1};
      g[1] = '{hs:8, hbp:6, hact:20, hfp:4, vs:2, vbp:3, vact:12, vfp:2,
               pol:1'b0, stall:1'b0, fill:24'h5A3C1E};
      g[2] = '{hs:2, hbp:2, hact:4, hfp:2, vs:1, vbp:1, vact:3, vfp:1,
               pol:1'b1, stall:1'b1, fill:24'h123456};
      rst_n = 1'b0;
      for (int k = 0; k < NI; k++) begin
         en[k]         = 1'b1;
         fifo_empty[k] = 1'b0;
         clr[k]        = 1'b0;
         seq[k]        = int'($urandom_range(32'h00FF_0000));
         fdata[k]      = seq[k][23:0];
         emp_left[k]   = 0;
         cnt_de[k]     = 0;
         cnt_fs[k]     = 0;
         cnt_hs[k]     = 0;
         cnt_vs[k]     = 0;
         m[k]          = m_reset(g[k]);
      end
      repeat (2) @(posedge clk);

      for (int it = 0; it < NITER; it++) begin
         @(negedge clk);
         rst_n = !(it == 3000 || (it > 3000 && $urandom_range(599) == 0));
         for (int k = 0; k < NI; k++) begin
            if (it < 2 * ft(g[k])) begin
               en[k]         = 1'b1;
               fifo_empty[k] = 1'b0;
               clr[k]        = 1'b0;
            end else begin
               en[k] = ($urandom_range(15) != 0);
               if (emp_left[k] > 0) emp_left[k]--;
               else if ($urandom_range(29) == 0) emp_left[k] = int'($urandom_range(12, 1));
               fifo_empty[k] = (emp_left[k] > 0);
               clr[k]        = ($urandom_range(7) == 0);
            end
            fdata[k] = seq[k][23:0];
         end
         #1;
         for (int k = 0; k < NI; k++) begin
            check($sformatf("u%0d.hsync", k), 64'(hsync[k]), 64'(m[k].hs));
            check($sformatf("u%0d.vsync", k), 64'(vsync[k]), 64'(m[k].vs));
            check($sformatf("u%0d.de", k), 64'(de[k]), 64'(m[k].de));
            check($sformatf("u%0d.pix_x", k), 64'(px[k]), 64'(m[k].px));
            check($sformatf("u%0d.pix_y", k), 64'(py[k]), 64'(m[k].py));
            check($sformatf("u%0d.frame_start", k), 64'(fs[k]), 64'(m[k].fs));
            check($sformatf("u%0d.underflow", k), 64'(uf[k]), 64'(m[k].uf));
            check($sformatf("u%0d.D_hi", k), 64'(d[k]), 64'(m[k].pq[23:12]));
            check($sformatf("u%0d.rd_en", k), 64'(rd_en[k]),
                  64'(m_rd(g[k], m[k], en[k], fifo_empty[k])));
            // Whole-frame statistics over the first two undisturbed frames.
            if (it >= 1 && it <= 2 * ft(g[k])) begin
               cnt_de[k] += int'(de[k]);
               cnt_fs[k] += int'(fs[k]);
               cnt_hs[k] += int'(hsync[k] == g[k].pol);
               cnt_vs[k] += int'(vsync[k] == g[k].pol);
            end
            if (it == 2 * ft(g[k])) begin
               check($sformatf("u%0d.frame_de_count", k), 64'(cnt_de[k]),
                     64'(2 * g[k].hact * g[k].vact));
               check($sformatf("u%0d.frame_start_count", k), 64'(cnt_fs[k]), 64'(2));
               check($sformatf("u%0d.hsync_asserted_count", k), 64'(cnt_hs[k]),
                     64'(2 * g[k].hs * (g[k].vs + g[k].vbp + g[k].vact + g[k].vfp)));
               check($sformatf("u%0d.vsync_asserted_count", k), 64'(cnt_vs[k]),
                     64'(2 * g[k].vs * ht(g[k])));
            end
         end
         @(posedge clk);
         for (int k = 0; k < NI; k++) begin
            if (m_rd(g[k], m[k], en[k], fifo_empty[k])) seq[k]++;
            m[k] = m_step(g[k], m[k], rst_n, en[k], fifo_empty[k], clr[k], fdata[k]);
         end
         #1;
         for (int k = 0; k < NI; k++)
            check($sformatf("u%0d.D_lo", k), 64'(d[k]), 64'(m[k].pq[11:0]));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
